rcc_rst_ctrl: RTL



---
 rtl/rcc_rst_ctrl.sv | 295 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rcc_rst_ctrl.sv
// ---------------------------------------------------------------------------
// rcc_rst_ctrl
//
// Reset controller for the RCC. It gathers NUM_SRC system reset sources and
// the NRST pad and stretches every system reset to at least STRETCH_CYC
// cycles. It drives the NRST pad and the system reset, then releases the
// power domains one at a time, each gated by its own power-good signal.
// Independent per-domain reset requests are served while the system is idle.
// Sticky cause flags feed the RCC reset status register.
//
// Ports
//   rcc_clk        controller clock
//   rcc_rst_n      asynchronous active-low power-on reset
//   rst_src        active-high system reset requests (asynchronous)
//   nrst_in        NRST pad input, active low (asynchronous)
//   dom_rst_req    active-high per-domain reset requests (asynchronous)
//   dom_pwr_ok     per-domain power good (asynchronous)
//   rsr_clr        single-cycle pulse clearing all reset flags
//   nrst_out       NRST pad drive, active low
//   sys_rst_n      system reset, active low
//   dom_rst_n      per-domain resets, active low
//   rsr_src_flags  sticky cause flags, one per rst_src bit
//   rsr_pin_flag   sticky flag, reset came from the NRST pad
//   rsr_por_flag   sticky flag, power-on reset
//   rst_busy       high while the system FSM is not idle
// ---------------------------------------------------------------------------
module rcc_rst_ctrl #(
    parameter int NUM_SRC     = 14,
    parameter int NUM_DOM     = 3,
    parameter int STRETCH_CYC = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               rcc_clk,
    input  logic               rcc_rst_n,
    input  logic [NUM_SRC-1:0] rst_src,
    input  logic               nrst_in,
    input  logic [NUM_DOM-1:0] dom_rst_req,
    input  logic [NUM_DOM-1:0] dom_pwr_ok,
    input  logic               rsr_clr,
    output logic               nrst_out,
    output logic               sys_rst_n,
    output logic [NUM_DOM-1:0] dom_rst_n,
    output logic [NUM_SRC-1:0] rsr_src_flags,
    output logic               rsr_pin_flag,
    output logic               rsr_por_flag,
    output logic               rst_busy
);

    localparam int CW = $clog2(STRETCH_CYC + 1);
    localparam int KW = $clog2(NUM_DOM + 1);
    localparam logic [CW-1:0] CntLast = CW'(STRETCH_CYC - 1);

    typedef enum logic [1:0] {IDLE, ASSERT, WAIT_REL, REL_DOM} sysState_e;
    typedef enum logic [1:0] {D_IDLE, D_ASSERT, D_WAIT} domState_e;

    logic [SYNC_STAGES-1:0][NUM_SRC-1:0] srcSync_q;
    logic [SYNC_STAGES-1:0]              nrstSync_q;
    logic [SYNC_STAGES-1:0][NUM_DOM-1:0] reqSync_q;
    logic [SYNC_STAGES-1:0][NUM_DOM-1:0] pwrOkSync_q;

    logic [NUM_SRC-1:0] srcSynced;
    logic               nrstSynced;
    logic [NUM_DOM-1:0] reqSynced;
    logic [NUM_DOM-1:0] pwrOkSynced;
    logic               sysReq;

    sysState_e          sysState_q, sysState_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [KW-1:0]      k_q, k_d;
    logic               nrstOut_q, nrstOut_d;
    logic               sysRstN_q, sysRstN_d;
    logic [NUM_DOM-1:0] domRstN_q, domRstN_d;
    logic               busy_q, busy_d;
    logic [NUM_DOM-1:0] sysDomRstN;

    domState_e          domState_q [NUM_DOM];
    domState_e          domState_d [NUM_DOM];
    logic [CW-1:0]      domCnt_q [NUM_DOM];
    logic [CW-1:0]      domCnt_d [NUM_DOM];
    logic [NUM_DOM-1:0] subDomRstN;
    logic               sysIdleStay;

    logic [NUM_SRC-1:0] srcFlags_q, srcFlags_d;
    logic               pinFlag_q, pinFlag_d;
    logic               porFlag_q, porFlag_d;

    // Input synchronisers. Stage 0 takes the raw pin, the last stage is the
    // one the logic uses. Every chain resets to its "asserted" level so the
    // block comes out of power-on reset as though every request were present.
    always_ff @(posedge rcc_clk or negedge rcc_rst_n) begin
        if (!rcc_rst_n) begin
            srcSync_q   <= '1;
            nrstSync_q  <= '0;
            reqSync_q   <= '1;
            pwrOkSync_q <= '0;
        end else begin
            srcSync_q   <= {srcSync_q[SYNC_STAGES-2:0], rst_src};
            nrstSync_q  <= {nrstSync_q[SYNC_STAGES-2:0], nrst_in};
            reqSync_q   <= {reqSync_q[SYNC_STAGES-2:0], dom_rst_req};
            pwrOkSync_q <= {pwrOkSync_q[SYNC_STAGES-2:0], dom_pwr_ok};
        end
    end

    assign srcSynced   = srcSync_q[SYNC_STAGES-1];
    assign nrstSynced  = nrstSync_q[SYNC_STAGES-1];
    assign reqSynced   = reqSync_q[SYNC_STAGES-1];
    assign pwrOkSynced = pwrOkSync_q[SYNC_STAGES-1];
    assign sysReq      = (|srcSynced) | ~nrstSynced;

    // System FSM state and registered outputs. Power-on reset lands directly
    // in ASSERT so a POR gets the same stretched sequence as any other reset.
    always_ff @(posedge rcc_clk or negedge rcc_rst_n) begin
        if (!rcc_rst_n) begin
            sysState_q <= ASSERT;
            cnt_q      <= '0;
            k_q        <= '0;
            nrstOut_q  <= 1'b0;
            sysRstN_q  <= 1'b0;
            domRstN_q  <= '0;
            busy_q     <= 1'b1;
        end else begin
            sysState_q <= sysState_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            nrstOut_q  <= nrstOut_d;
            sysRstN_q  <= sysRstN_d;
            domRstN_q  <= domRstN_d;
            busy_q     <= busy_d;
        end
    end

    // System FSM next state. The pad is released on leaving ASSERT so our own
    // drive on NRST cannot hold us in WAIT_REL forever. Domains come up in
    // index order, one per cycle, each waiting for its power good. A new
    // request while domains are coming up restarts the whole stretch.
    always_comb begin
        sysState_d = sysState_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        nrstOut_d  = nrstOut_q;
        sysRstN_d  = sysRstN_q;
        sysDomRstN = domRstN_q;
        busy_d     = busy_q;
        case (sysState_q)
            IDLE: begin
                if (sysReq) begin
                    sysState_d = ASSERT;
                    cnt_d      = '0;
                    nrstOut_d  = 1'b0;
                    sysRstN_d  = 1'b0;
                    sysDomRstN = '0;
                    busy_d     = 1'b1;
                end
            end
            ASSERT: begin
                nrstOut_d  = 1'b0;
                sysRstN_d  = 1'b0;
                sysDomRstN = '0;
                busy_d     = 1'b1;
                if (cnt_q == CntLast) begin
                    sysState_d = WAIT_REL;
                    cnt_d      = '0;
                    nrstOut_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_REL: begin
                if (!sysReq) begin
                    sysState_d = REL_DOM;
                    k_d        = '0;
                    sysRstN_d  = 1'b1;
                end
            end
            REL_DOM: begin
                if (sysReq) begin
                    sysState_d = ASSERT;
                    cnt_d      = '0;
                    nrstOut_d  = 1'b0;
                    sysRstN_d  = 1'b0;
                    sysDomRstN = '0;
                end else begin
                    for (int i = 0; i < NUM_DOM; i++) begin
                        if (k_q == KW'(i) && pwrOkSynced[i]) begin
                            sysDomRstN[i] = 1'b1;
                            if (i == NUM_DOM - 1) begin
                                sysState_d = IDLE;
                                k_d        = '0;
                                busy_d     = 1'b0;
                            end else begin
                                k_d = k_q + KW'(1);
                            end
                        end
                    end
                end
            end
            default: begin
                sysState_d = ASSERT;
                cnt_d      = '0;
            end
        endcase
    end

    // Per-domain sub-FSM state registers.
    always_ff @(posedge rcc_clk or negedge rcc_rst_n) begin
        if (!rcc_rst_n) begin
            for (int i = 0; i < NUM_DOM; i++) begin
                domState_q[i] <= D_IDLE;
                domCnt_q[i]   <= '0;
            end
        end else begin
            domState_q <= domState_d;
            domCnt_q   <= domCnt_d;
        end
    end

    // Per-domain sub-FSMs. They only run while the system FSM sits in IDLE
    // and stays there; as soon as the system leaves IDLE they are parked and
    // the system FSM takes over every domain reset.
    assign sysIdleStay = (sysState_q == IDLE) && (sysState_d == IDLE);

    always_comb begin
        subDomRstN = domRstN_q;
        for (int i = 0; i < NUM_DOM; i++) begin
            domState_d[i] = domState_q[i];
            domCnt_d[i]   = domCnt_q[i];
            if (!sysIdleStay) begin
                domState_d[i] = D_IDLE;
                domCnt_d[i]   = '0;
            end else begin
                case (domState_q[i])
                    D_IDLE: begin
                        if (reqSynced[i]) begin
                            domState_d[i] = D_ASSERT;
                            domCnt_d[i]   = '0;
                            subDomRstN[i] = 1'b0;
                        end
                    end
                    D_ASSERT: begin
                        if (domCnt_q[i] == CntLast) begin
                            domState_d[i] = D_WAIT;
                            domCnt_d[i]   = '0;
                        end else begin
                            domCnt_d[i] = domCnt_q[i] + CW'(1);
                        end
                    end
                    D_WAIT: begin
                        if (!reqSynced[i] && pwrOkSynced[i]) begin
                            domState_d[i] = D_IDLE;
                            subDomRstN[i] = 1'b1;
                        end
                    end
                    default: begin
                        domState_d[i] = D_IDLE;
                        domCnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    assign domRstN_d = sysIdleStay ? subDomRstN : sysDomRstN;

    // Sticky reset-cause flags. A clear and a set in the same cycle leaves
    // the flag set. The pin flag only counts pad activity seen from IDLE, so
    // our own NRST pulse looping back through the pad is ignored.
    always_comb begin
        srcFlags_d = (rsr_clr ? '0 : srcFlags_q) | srcSynced;
        pinFlag_d  = (rsr_clr ? 1'b0 : pinFlag_q) |
                     ((sysState_q == IDLE) && !nrstSynced);
        porFlag_d  = rsr_clr ? 1'b0 : porFlag_q;
    end

    // Flag registers; only the power-on reset initialises them.
    always_ff @(posedge rcc_clk or negedge rcc_rst_n) begin
        if (!rcc_rst_n) begin
            srcFlags_q <= '0;
            pinFlag_q  <= 1'b0;
            porFlag_q  <= 1'b1;
        end else begin
            srcFlags_q <= srcFlags_d;
            pinFlag_q  <= pinFlag_d;
            porFlag_q  <= porFlag_d;
        end
    end

    assign nrst_out      = nrstOut_q;
    assign sys_rst_n     = sysRstN_q;
    assign dom_rst_n     = domRstN_q;
    assign rst_busy      = busy_q;
    assign rsr_src_flags = srcFlags_q;
    assign rsr_pin_flag  = pinFlag_q;
    assign rsr_por_flag  = porFlag_q;

endmodule
